// File: rtl/bcd3_display_scan.sv
// bcd3_display_scan
//   Display end of the 3-digit BCD count bus. A BCD triple is captured into a
//   pending register on load and promoted to the display shadow only at a
//   frame boundary, so a frame never mixes old and new digits. The shadow is
//   decoded to 7-segment and the three digits are time-multiplexed
//   hun -> ten -> unit, each for SCAN_DIV enabled clocks, with optional
//   leading-zero blanking.
//
//   Ports
//     clk         rising-edge clock
//     rst         asynchronous, active-high reset
//     hun_i       BCD hundreds digit to capture
//     ten_i       BCD tens digit to capture
//     unit_i      BCD units digit to capture
//     load        capture hun_i/ten_i/unit_i on this edge
//     en          scan enable; 0 freezes the scan and darkens the display
//     seg         {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//     an          {hun,ten,unit} digit select, polarity set by AN_ACTIVE_LOW
//     frame_done  one-cycle pulse after the last clock of each unit slot
//     digit_err   high while the displayed slot holds a value above 9
//
//   Scan states
//     state     | meaning
//     ----------+-------------------------------------------
//     SLOT_HUN  | hundreds digit selected (first slot of frame)
//     SLOT_TEN  | tens digit selected
//     SLOT_UNIT | units digit selected; its wrap ends the frame

module bcd3_display_scan #(
    parameter int SCAN_DIV       = 4,
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hun_i,
    input  logic [3:0] ten_i,
    input  logic [3:0] unit_i,
    input  logic       load,
    input  logic       en,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done,
    output logic       digit_err
);

    localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]    AN_OFF     = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

    typedef enum logic [1:0] {
        SLOT_HUN  = 2'd0,
        SLOT_TEN  = 2'd1,
        SLOT_UNIT = 2'd2
    } slot_t;

    slot_t         slot;
    logic [PW-1:0] presc;
    logic [11:0]   shadow;
    logic [11:0]   pending;
    logic          pend_flag;

    logic          slot_wrap;
    logic          frame_end;
    logic [3:0]    cur_digit;
    logic          hun_zero;
    logic          ten_zero;
    logic          blank_slot;
    logic [6:0]    seg_lit;
    logic [2:0]    an_sel;
    logic          err_now;

    // Active-high segment pattern; anything above 9 shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_wrap = en && (presc == PRESC_LAST);
        frame_end = slot_wrap && (slot == SLOT_UNIT);
    end

    // Next pin values are built from the slot/shadow/en seen this cycle and
    // registered, giving one clock of latency from a slot change to the pins.
    always_comb begin
        hun_zero   = (shadow[11:8] == 4'd0);
        ten_zero   = (shadow[7:4] == 4'd0);
        cur_digit  = 4'd0;
        an_sel     = 3'b000;
        blank_slot = 1'b0;
        case (slot)
            SLOT_HUN: begin
                cur_digit = shadow[11:8];
                an_sel    = 3'b100;
                if (BLANK_LZ) blank_slot = hun_zero;
            end
            SLOT_TEN: begin
                cur_digit = shadow[7:4];
                an_sel    = 3'b010;
                // An invalid hundreds digit is not zero, so tens stays lit.
                if (BLANK_LZ) blank_slot = hun_zero && ten_zero;
            end
            SLOT_UNIT: begin
                cur_digit = shadow[3:0];
                an_sel    = 3'b001;
            end
            default: begin
                cur_digit = 4'd0;
                an_sel    = 3'b000;
            end
        endcase

        if (en && !blank_slot) begin
            seg_lit = seg_decode(cur_digit);
        end else begin
            seg_lit = 7'h00;
            an_sel  = 3'b000;
        end
        err_now = en && !blank_slot && (cur_digit > 4'd9);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot       <= SLOT_HUN;
            presc      <= '0;
            shadow     <= 12'h000;
            pending    <= 12'h000;
            pend_flag  <= 1'b0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
            digit_err  <= 1'b0;
        end else begin
            if (en) begin
                if (slot_wrap) begin
                    presc <= '0;
                    case (slot)
                        SLOT_HUN:  slot <= SLOT_TEN;
                        SLOT_TEN:  slot <= SLOT_UNIT;
                        default:   slot <= SLOT_HUN;
                    endcase
                end else begin
                    presc <= presc + 1'b1;
                end
            end

            // A load landing exactly on the frame boundary goes straight to
            // the shadow so it is visible from the very next hun slot.
            if (load && frame_end) begin
                shadow    <= {hun_i, ten_i, unit_i};
                pend_flag <= 1'b0;
            end else if (load) begin
                pending   <= {hun_i, ten_i, unit_i};
                pend_flag <= 1'b1;
            end else if (frame_end && pend_flag) begin
                shadow    <= pending;
                pend_flag <= 1'b0;
            end

            seg        <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
            an         <= AN_ACTIVE_LOW ? ~an_sel : an_sel;
            frame_done <= frame_end;
            digit_err  <= err_now;
        end
    end

endmodule

// File: tb/tb_bcd3_display_scan.sv
// tb_bcd3_display_scan
//   Drives two instances (default build and an active-high, no-blanking,
//   SCAN_DIV=3 build) with random digits, loads, enables and occasional
//   mid-cycle resets, and compares every output each cycle against a
//   position-counter reference model.

module tb_bcd3_display_scan;

    logic       clk;
    logic       rst;
    logic [3:0] hun_i, ten_i, unit_i;
    logic       load, en;

    logic [6:0] seg0, seg1;
    logic [2:0] an0, an1;
    logic       fd0, fd1, err0, err1;

    int n_chk = 0;
    int n_err = 0;

    bcd3_display_scan #(
        .SCAN_DIV(4), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .hun_i(hun_i), .ten_i(ten_i), .unit_i(unit_i),
        .load(load), .en(en), .seg(seg0), .an(an0), .frame_done(fd0), .digit_err(err0)
    );

    bcd3_display_scan #(
        .SCAN_DIV(3), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .hun_i(hun_i), .ten_i(ten_i), .unit_i(unit_i),
        .load(load), .en(en), .seg(seg1), .an(an1), .frame_done(fd1), .digit_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: scan position 0..3*div-1 within a frame.
    int         div [2] = '{4, 3};
    bit         blz [2] = '{1'b1, 1'b0};
    bit         sal [2] = '{1'b1, 1'b0};
    bit         aal [2] = '{1'b1, 1'b0};
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    int         m_pos [2];
    logic [3:0] m_sh  [2][3];
    logic [3:0] m_pd  [2][3];
    bit         m_pf  [2];
    logic [6:0] m_seg [2];
    logic [2:0] m_an  [2];
    logic       m_fd  [2];
    logic       m_err [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pos[k] = 0;
            m_pf[k]  = 1'b0;
            for (int j = 0; j < 3; j++) begin
                m_sh[k][j] = 4'd0;
                m_pd[k][j] = 4'd0;
            end
            m_seg[k] = sal[k] ? 7'h7F : 7'h00;
            m_an[k]  = aal[k] ? 3'b111 : 3'b000;
            m_fd[k]  = 1'b0;
            m_err[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int         n;
        int         sl;
        logic [3:0] d;
        bit         blank;
        bit         bnd;
        logic [6:0] lit;
        logic [2:0] sel;
        n  = 3 * div[k];
        sl = m_pos[k] / div[k];
        d  = m_sh[k][sl];
        blank = blz[k] && ((sl == 0 && m_sh[k][0] == 4'd0) ||
                           (sl == 1 && m_sh[k][0] == 4'd0 && m_sh[k][1] == 4'd0));
        if (en && !blank) begin
            lit = seg_tab[d];
            sel = 3'b100 >> sl;
        end else begin
            lit = 7'h00;
            sel = 3'b000;
        end
        m_seg[k] = sal[k] ? ~lit : lit;
        m_an[k]  = aal[k] ? ~sel : sel;
        m_err[k] = en && !blank && (d > 4'd9);
        bnd      = en && (m_pos[k] == n - 1);
        m_fd[k]  = bnd;
        if (load && bnd) begin
            m_sh[k][0] = hun_i; m_sh[k][1] = ten_i; m_sh[k][2] = unit_i;
            m_pf[k] = 1'b0;
        end else if (load) begin
            m_pd[k][0] = hun_i; m_pd[k][1] = ten_i; m_pd[k][2] = unit_i;
            m_pf[k] = 1'b1;
        end else if (bnd && m_pf[k]) begin
            for (int j = 0; j < 3; j++) m_sh[k][j] = m_pd[k][j];
            m_pf[k] = 1'b0;
        end
        if (en) m_pos[k] = (m_pos[k] + 1) % n;
    endtask

    task automatic compare_all(input int cyc);
        chk($sformatf("d0_seg c%0d", cyc), 32'(seg0), 32'(m_seg[0]));
        chk($sformatf("d0_an c%0d",  cyc), 32'(an0),  32'(m_an[0]));
        chk($sformatf("d0_fd c%0d",  cyc), 32'(fd0),  32'(m_fd[0]));
        chk($sformatf("d0_err c%0d", cyc), 32'(err0), 32'(m_err[0]));
        chk($sformatf("d1_seg c%0d", cyc), 32'(seg1), 32'(m_seg[1]));
        chk($sformatf("d1_an c%0d",  cyc), 32'(an1),  32'(m_an[1]));
        chk($sformatf("d1_fd c%0d",  cyc), 32'(fd1),  32'(m_fd[1]));
        chk($sformatf("d1_err c%0d", cyc), 32'(err1), 32'(m_err[1]));
    endtask

    function automatic logic [3:0] rand_digit();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)  return 4'd0;
        if (r == 4) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(1, 9));
    endfunction

    // Reset asserted between edges; pins must go inactive with no clock.
    task automatic async_reset(input int cyc);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all(cyc);
        @(negedge clk);
        compare_all(cyc);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; load = 1'b0;
        hun_i = 4'd0; ten_i = 4'd0; unit_i = 4'd0;
        #1;
        rst = 1'b1;
        #2;
        model_reset();
        compare_all(-1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed start: load 1/2/3 with scan enabled.
        en = 1'b1; load = 1'b1;
        hun_i = 4'd1; ten_i = 4'd2; unit_i = 4'd3;
        model_step(0); model_step(1);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            compare_all(cyc);
            if (cyc == 1100 || cyc == 2300) async_reset(cyc);

            en = ($urandom_range(0, 9) != 0);
            if (cyc % 400 > 380) en = 1'b0;
            if (en && (m_pos[0] == 3 * div[0] - 1 || m_pos[1] == 3 * div[1] - 1))
                load = ($urandom_range(0, 1) == 1);
            else
                load = ($urandom_range(0, 7) == 0);
            hun_i  = rand_digit();
            ten_i  = rand_digit();
            unit_i = rand_digit();
            model_step(0);
            model_step(1);
        end

        @(negedge clk);
        compare_all(3000);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
